mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM pipeline stage of the 8-bit processor.
- Holds a 256x8 data memory and resolves conditional and unconditional jumps.
- Registers the writeback data and writeback controls into the MEM/WB boundary.
- Sits between the execute stage (accumulator result, register operand, flags) and the writeback stage.

Parameters:
- DATA_W, 8, width of data, accumulator, register operand and PC.
- ADDR_W, 8, data-memory address width.
- DEPTH, 256, number of data-memory words; must equal 2**ADDR_W.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- Wr  in  1  register-file write request from EX.
- Wm  in  1  memory write enable.
- Rm  in  1  memory read enable.
- Neq  in  1  conditional-jump polarity: 1 = jump if not zero, 0 = jump if zero.
- J  in  1  unconditional jump.
- JC  in  1  conditional jump.
- PC  in  DATA_W  address of the current instruction; used as the link value on jumps.
- zeroOut  in  1  ALU zero flag from EX.
- acOutValue  in  DATA_W  accumulator/ALU result; used as store data and default writeback data.
- RegVal  in  DATA_W  register operand; used as memory address.
- data_out  out  DATA_W  registered writeback data.
- saidaA  out  1  registered jump-taken flag.
- Wr_MEM  out  1  registered copy of Wr.
- Rm_MEM  out  1  registered copy of Rm.

Behaviour:
- Reset (reset_n low, asynchronous): data_out=0, saidaA=0, Wr_MEM=0, Rm_MEM=0. Memory array is not cleared unless MEM_CLEAR_EN is defined.
- Release of reset is synchronous to the next rising clock edge.
- All outputs update on the rising clock edge: one-cycle latency from inputs.
- Store: if Wm=1, mem[RegVal] <= acOutValue at the rising edge.
- Load: if Rm=1, data_out <= mem[RegVal]. The read happens in the same edge, so the value is visible the cycle after Rm.
- Wm and Rm asserted together, same address: read-before-write; data_out gets the old contents, and the new value is stored.
- data_out priority:
  1. Rm -> memory word.
  2. else J -> PC (link value).
  3. else acOutValue.
- Jump decision: taken = J | (JC & (Neq ? ~zeroOut : zeroOut)); saidaA <= taken.
- J and JC both asserted: J dominates; taken=1.
- Wr_MEM <= Wr and Rm_MEM <= Rm every cycle; there is no gating by the jump.
- Addresses wrap naturally over the 8-bit range; there are no out-of-range addresses.
- Unknown or undriven acOutValue during a write stores X. The bench must drive a defined value before any store.

Optional Feature:
- Macro: MEM_CLEAR_EN.
- Defined: asserting reset_n low also clears all DEPTH words to 0 asynchronously, so a read after reset returns 0.
- Not defined: memory contents are preserved across reset and are undefined at power-up; only the output registers reset.

Decomposition:
- Shared package (proc_pkg): DATA_W/ADDR_W constants and a typedef for the 8-bit data word. Other stages reuse them.
- One natural sub-module: data_ram, a single-port synchronous read/write array with the optional clear.
- Jump logic and the output register stay in mem_stage.

Test Plan:
- Reset: hold reset_n=0 with random inputs -> data_out=0x00, saidaA=0, Wr_MEM=0, Rm_MEM=0, all asynchronously, before any clock edge.
- Store then load: cycle 1 Wm=1, RegVal=0x10, acOutValue=0x5A; cycle 2 Rm=1, RegVal=0x10 -> data_out=0x5A, Rm_MEM=1 one edge later. With MEM_CLEAR_EN, a load from 0x20 after reset -> 0x00.
- Read-before-write: mem[0x07]=0x11 preloaded; Wm=Rm=1, RegVal=0x07, acOutValue=0x22 -> data_out=0x11; a following read returns 0x22.
- Conditional jumps, registered one edge later:
  - JC=1, Neq=0, zeroOut=1 -> saidaA=1.
  - JC=1, Neq=0, zeroOut=0 -> saidaA=0.
  - JC=1, Neq=1, zeroOut=0 -> saidaA=1.
  - JC=1, Neq=1, zeroOut=1 -> saidaA=0.
- Unconditional jump and link: J=1, PC=0x3C, Rm=0 -> saidaA=1, data_out=0x3C.
- Plain ALU writeback: Wr=1, acOutValue=0x9F, all others 0 -> data_out=0x9F, Wr_MEM=1, saidaA=0.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the 8-bit processor pipeline stages.
// Holds the word and address widths, the data word type and the jump-decision helper.
package proc_pkg;

    localparam int WORD_W     = 8;
    localparam int MEM_ADDR_W = 8;

    typedef logic [WORD_W-1:0] word_t;

    // Conditional jumps test the ALU zero flag; Neq selects which polarity counts as taken.
    function automatic logic jump_taken(input logic j, input logic jc, input logic neq,
                                        input logic zero);
        return j | (jc & (neq ? ~zero : zero));
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Bundle between the execute stage and the MEM stage, including the MEM/WB register outputs.
// The master side is the producer of EX results; the slave side is mem_stage.
interface mem_stage_if
    import proc_pkg::*;
#(
    parameter int DATA_W = WORD_W
) ();

    logic              Wr;
    logic              Wm;
    logic              Rm;
    logic              Neq;
    logic              J;
    logic              JC;
    logic [DATA_W-1:0] PC;
    logic              zeroOut;
    logic [DATA_W-1:0] acOutValue;
    logic [DATA_W-1:0] RegVal;
    logic [DATA_W-1:0] data_out;
    logic              saidaA;
    logic              Wr_MEM;
    logic              Rm_MEM;

    modport master (
        output Wr, Wm, Rm, Neq, J, JC, PC, zeroOut, acOutValue, RegVal,
        input  data_out, saidaA, Wr_MEM, Rm_MEM
    );

    modport slave (
        input  Wr, Wm, Rm, Neq, J, JC, PC, zeroOut, acOutValue, RegVal,
        output data_out, saidaA, Wr_MEM, Rm_MEM
    );

endinterface

// File: rtl/mem_stage_data_ram.sv
// data_ram: single-port data memory with synchronous write and combinational read.
// With MEM_CLEAR_EN defined, an active-low reset clears every word asynchronously.
module data_ram
    import proc_pkg::*;
#(
    parameter int DATA_W = WORD_W,
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              i_clk,
`ifdef MEM_CLEAR_EN
    input  logic              i_rst_n,
`endif
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // The read is sampled by the stage register on the same edge as any write,
    // which gives read-before-write on a shared address.
    assign o_rdata = r_mem[i_addr];

`ifdef MEM_CLEAR_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end
`else
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end
`endif

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage -- data memory access, jump resolution and the MEM/WB register.
// Optional build macro MEM_CLEAR_EN makes reset also clear the data memory.
module mem_stage
    import proc_pkg::*;
#(
    parameter int DATA_W = WORD_W,
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic       clock,
    input  logic       reset_n,
    mem_stage_if.slave bus
);

    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] w_wb_next;
    logic              w_taken;

    logic [DATA_W-1:0] r_data_out;
    logic              r_saidaA;
    logic              r_wr_mem;
    logic              r_rm_mem;

    assign w_addr = bus.RegVal[ADDR_W-1:0];

    data_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_data_ram (
        .i_clk   (clock),
`ifdef MEM_CLEAR_EN
        .i_rst_n (reset_n),
`endif
        .i_we    (bus.Wm),
        .i_addr  (w_addr),
        .i_wdata (bus.acOutValue),
        .o_rdata (w_rdata)
    );

    // Writeback source: a load wins, then the link value of a jump, then the ALU result.
    always_comb begin
        w_wb_next = bus.acOutValue;
        if (bus.Rm) begin
            w_wb_next = w_rdata;
        end else if (bus.J) begin
            w_wb_next = bus.PC;
        end
    end

    assign w_taken = jump_taken(bus.J, bus.JC, bus.Neq, bus.zeroOut);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out <= '0;
            r_saidaA   <= 1'b0;
            r_wr_mem   <= 1'b0;
            r_rm_mem   <= 1'b0;
        end else begin
            r_data_out <= w_wb_next;
            r_saidaA   <= w_taken;
            r_wr_mem   <= bus.Wr;
            r_rm_mem   <= bus.Rm;
        end
    end

    assign bus.data_out = r_data_out;
    assign bus.saidaA   = r_saidaA;
    assign bus.Wr_MEM   = r_wr_mem;
    assign bus.Rm_MEM   = r_rm_mem;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: each issued cycle pushes its expected MEM/WB contents,
// a negedge monitor pops and compares; MEM_CLEAR_EN selects the memory-clear expectations.
module tb_mem_stage;

    typedef struct {
        logic [7:0] data;
        bit         data_known;
        logic       saidaA;
        logic       wr;
        logic       rm;
    } exp_t;

    logic clk;
    logic rst_n;

    mem_stage_if #(.DATA_W(8)) bus ();

    mem_stage dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    exp_t       sb_q[$];
    logic [7:0] mem_model [256];
    bit         mem_known [256];
    int         n_checks = 0;
    int         n_fail   = 0;

    initial begin
        clk = 1'b0;
        #5;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, required 0x%02h at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
`ifdef MEM_CLEAR_EN
        for (int i = 0; i < 256; i++) begin
            mem_model[i] = 8'h00;
            mem_known[i] = 1'b1;
        end
`endif
    endtask

    // Drive one cycle of EX inputs and record what the MEM/WB register must hold after the edge.
    task automatic issue(input logic wr, input logic wm, input logic rm, input logic neq,
                         input logic j, input logic jc, input logic zero,
                         input logic [7:0] pc, input logic [7:0] ac, input logic [7:0] rv);
        exp_t e;
        @(negedge clk);
        #1;
        bus.Wr = wr; bus.Wm = wm; bus.Rm = rm; bus.Neq = neq; bus.J = j; bus.JC = jc;
        bus.zeroOut = zero; bus.PC = pc; bus.acOutValue = ac; bus.RegVal = rv;
        e.wr = wr;
        e.rm = rm;
        if (j)
            e.saidaA = 1'b1;
        else if (jc)
            e.saidaA = neq ? (zero == 1'b0) : (zero == 1'b1);
        else
            e.saidaA = 1'b0;
        e.data_known = 1'b1;
        if (rm) begin
            e.data       = mem_model[rv];
            e.data_known = mem_known[rv];
        end else if (j) begin
            e.data = pc;
        end else begin
            e.data = ac;
        end
        if (wm) begin
            mem_model[rv] = ac;
            mem_known[rv] = 1'b1;
        end
        sb_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic issue_random();
        logic [7:0] rv;
        rv = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
        issue(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
              1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), rv);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".data_out"}, bus.data_out, 8'h00);
        check({tag, ".saidaA"},   {7'd0, bus.saidaA}, 8'h00);
        check({tag, ".Wr_MEM"},   {7'd0, bus.Wr_MEM}, 8'h00);
        check({tag, ".Rm_MEM"},   {7'd0, bus.Rm_MEM}, 8'h00);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.data_known)
                check("data_out", bus.data_out, e.data);
            check("saidaA", {7'd0, bus.saidaA}, {7'd0, e.saidaA});
            check("Wr_MEM", {7'd0, bus.Wr_MEM}, {7'd0, e.wr});
            check("Rm_MEM", {7'd0, bus.Rm_MEM}, {7'd0, e.rm});
        end
    end

    initial begin
        int waited;
        for (int i = 0; i < 256; i++) begin
            mem_model[i] = 8'h00;
            mem_known[i] = 1'b0;
        end
        rst_n = 1'b1;
        bus.Wr = 1'($urandom); bus.Wm = 1'($urandom); bus.Rm = 1'($urandom);
        bus.Neq = 1'($urandom); bus.J = 1'($urandom); bus.JC = 1'($urandom);
        bus.zeroOut = 1'($urandom); bus.PC = 8'($urandom);
        bus.acOutValue = 8'($urandom); bus.RegVal = 8'($urandom);

        // Reset takes effect before the first clock edge (first posedge at t=10).
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_reset_outputs("reset_async");
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;

`ifdef MEM_CLEAR_EN
        issue(0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h20);
`endif
        // Store then load.
        issue(0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h5A, 8'h10);
        issue(0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h10);
        // Read-before-write on one address.
        issue(0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h11, 8'h07);
        issue(0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h22, 8'h07);
        issue(0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h07);
        // Conditional jumps over both polarities and both flag values.
        issue(0, 0, 0, 0, 0, 1, 1, 8'h40, 8'h01, 8'h00);
        issue(0, 0, 0, 0, 0, 1, 0, 8'h41, 8'h02, 8'h00);
        issue(0, 0, 0, 1, 0, 1, 0, 8'h42, 8'h03, 8'h00);
        issue(0, 0, 0, 1, 0, 1, 1, 8'h43, 8'h04, 8'h00);
        // Unconditional jump and link, J with JC, plain ALU writeback.
        issue(0, 0, 0, 0, 1, 0, 0, 8'h3C, 8'h77, 8'h00);
        issue(1, 0, 0, 1, 1, 1, 1, 8'hC3, 8'h66, 8'h00);
        issue(1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h9F, 8'h00);

        // Fill every word so random loads all have a defined expectation.
        for (int a = 0; a < 256; a++)
            issue(1'($urandom), 1, 0, 1'($urandom), 0, 1'($urandom), 1'($urandom),
                  8'($urandom), 8'($urandom), 8'(a));
        for (int n = 0; n < 400; n++)
            issue_random();

        // Leave non-zero outputs in the register, then reset mid-cycle.
        issue(1, 0, 0, 0, 1, 0, 0, 8'hA5, 8'hFF, 8'h00);
        @(negedge clk);
        #1 rst_n = 1'b0;
        model_reset();
        #1 check_reset_outputs("reset_midrun");
        @(negedge clk);
        #1 rst_n = 1'b1;
        for (int a = 0; a < 8; a++)
            issue(0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'(a * 37));
        for (int n = 0; n < 100; n++)
            issue_random();

        waited = 0;
        while (sb_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        n_checks++;
        if (sb_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
